// File: rtl/lock_pkg.sv
// Shared types, defaults and the button-digit decoder for the combination-lock supervisor.
package lock_pkg;

    localparam int unsigned CODE_LEN_DEF = 5;
    localparam logic [CODE_LEN_DEF-1:0] DEFAULT_CODE_DEF = 5'b01011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_PROG    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    typedef struct packed {
        logic valid;
        logic bad;
        logic value;
    } digit_t;

    // Both buttons in one cycle still count as a single digit, flagged bad.
    function automatic digit_t decode_digit(input logic b0, input logic b1);
        digit_t d;
        d.valid = b0 | b1;
        d.bad   = b0 & b1;
        d.value = b1 & ~b0;
        return d;
    endfunction

endpackage

// File: rtl/lock_supervisor_if.sv
// Button-pulse inputs and status outputs of the lock supervisor.
interface lock_supervisor_if;
    logic       b0_pulse;
    logic       b1_pulse;
    logic       enter_pulse;
    logic       prog_pulse;
    logic       unlocked;
    logic       lockout;
    logic       err;
    logic       prog_ok;
    logic [1:0] fail_cnt;
    logic [3:0] hex_display;

    modport master (
        output b0_pulse, b1_pulse, enter_pulse, prog_pulse,
        input  unlocked, lockout, err, prog_ok, fail_cnt, hex_display
    );

    modport slave (
        input  b0_pulse, b1_pulse, enter_pulse, prog_pulse,
        output unlocked, lockout, err, prog_ok, fail_cnt, hex_display
    );
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter that holds at zero; zero flag is registered alongside the count.
module lock_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zero_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/lock_supervisor.sv
// Combination-lock supervisor: digit entry, code check, fail/lockout, timed open window, reprogramming.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int unsigned          CODE_LEN       = CODE_LEN_DEF,
    parameter logic [CODE_LEN-1:0]  DEFAULT_CODE   = DEFAULT_CODE_DEF,
    parameter int unsigned          MAX_FAIL       = 3,
    parameter int unsigned          UNLOCK_CYCLES  = 500,
    parameter int unsigned          LOCKOUT_CYCLES = 1000,
    parameter int unsigned          CNT_W          = 16
) (
    input  logic          clk,
    input  logic          reset_in,
    lock_supervisor_if.slave bus
);

    localparam int unsigned DCW = $clog2(CODE_LEN + 1);
    localparam logic [DCW-1:0]   FULL_CNT   = DCW'(CODE_LEN);
    localparam logic [CNT_W-1:0] UNLOCK_LD  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LD = CNT_W'(LOCKOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] entry_sr_q, entry_sr_d;
    logic [CODE_LEN-1:0] code_q, code_d;
    logic [DCW-1:0]      digit_cnt_q, digit_cnt_d;
    logic                bad_q, bad_d;
    logic [1:0]          fail_cnt_q, fail_cnt_d;
    logic                unlocked_q, unlocked_d;
    logic                lockout_q, lockout_d;
    logic                err_q, err_d;
    logic                prog_ok_q, prog_ok_d;
    logic [3:0]          hex_q, hex_d;

    logic                tmr_load_c;
    logic [CNT_W-1:0]    tmr_val_c;
    logic                tmr_zero;

    digit_t              dig_c;
    logic [CODE_LEN-1:0] cap_sr_c;
    logic [DCW-1:0]      cap_cnt_c;
    logic                cap_bad_c;
    logic                full_c;
    logic                match_c;
    logic                entry_ok_c;

    lock_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_in (reset_in),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .zero     (tmr_zero)
    );

    // Shift-in of one digit; the cast keeps the low CODE_LEN bits of the widened vector.
    always_comb begin
        dig_c      = decode_digit(bus.b0_pulse, bus.b1_pulse);
        full_c     = (digit_cnt_q == FULL_CNT);
        cap_sr_c   = CODE_LEN'({entry_sr_q, dig_c.value});
        cap_cnt_c  = full_c ? digit_cnt_q : digit_cnt_q + DCW'(1);
        cap_bad_c  = bad_q | dig_c.bad | full_c;
        entry_ok_c = full_c && !bad_q;
        match_c    = entry_ok_c && (entry_sr_q == code_q);
    end

    always_comb begin
        state_d     = state_q;
        entry_sr_d  = entry_sr_q;
        code_d      = code_q;
        digit_cnt_d = digit_cnt_q;
        bad_d       = bad_q;
        fail_cnt_d  = fail_cnt_q;
        err_d       = 1'b0;
        prog_ok_d   = 1'b0;
        tmr_load_c  = 1'b0;
        tmr_val_c   = UNLOCK_LD;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.enter_pulse && dig_c.valid) begin
                    entry_sr_d  = CODE_LEN'(dig_c.value);
                    digit_cnt_d = DCW'(1);
                    bad_d       = dig_c.bad;
                    tmr_load_c  = 1'b1;
                    state_d     = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (bus.enter_pulse) begin
                    state_d = ST_CHECK;
                end else if (dig_c.valid) begin
                    entry_sr_d  = cap_sr_c;
                    digit_cnt_d = cap_cnt_c;
                    bad_d       = cap_bad_c;
                    tmr_load_c  = 1'b1;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (match_c) begin
                    fail_cnt_d = 2'd0;
                    tmr_load_c = 1'b1;
                    state_d    = ST_OPEN;
                end else if (({1'b0, fail_cnt_q} + 3'd1) == 3'(MAX_FAIL)) begin
                    err_d      = 1'b1;
                    fail_cnt_d = 2'd0;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = LOCKOUT_LD;
                    state_d    = ST_LOCKOUT;
                end else begin
                    err_d      = 1'b1;
                    fail_cnt_d = fail_cnt_q + 2'd1;
                    state_d    = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (bus.enter_pulse) begin
                    state_d = ST_IDLE;
                end else if (bus.prog_pulse) begin
                    entry_sr_d  = '0;
                    digit_cnt_d = '0;
                    bad_d       = 1'b0;
                    tmr_load_c  = 1'b1;
                    state_d     = ST_PROG;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (bus.enter_pulse) begin
                    if (entry_ok_c) begin
                        code_d    = entry_sr_q;
                        prog_ok_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d = ST_IDLE;
                end else if (dig_c.valid) begin
                    entry_sr_d  = cap_sr_c;
                    digit_cnt_d = cap_cnt_c;
                    bad_d       = cap_bad_c;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs follow the next state so they register in step with it.
        unlocked_d = (state_d == ST_OPEN) || (state_d == ST_PROG);
        lockout_d  = (state_d == ST_LOCKOUT);
        hex_d      = {1'b0, state_d};
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= ST_IDLE;
            entry_sr_q  <= '0;
            code_q      <= DEFAULT_CODE;
            digit_cnt_q <= '0;
            bad_q       <= 1'b0;
            fail_cnt_q  <= 2'd0;
            unlocked_q  <= 1'b0;
            lockout_q   <= 1'b0;
            err_q       <= 1'b0;
            prog_ok_q   <= 1'b0;
            hex_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            entry_sr_q  <= entry_sr_d;
            code_q      <= code_d;
            digit_cnt_q <= digit_cnt_d;
            bad_q       <= bad_d;
            fail_cnt_q  <= fail_cnt_d;
            unlocked_q  <= unlocked_d;
            lockout_q   <= lockout_d;
            err_q       <= err_d;
            prog_ok_q   <= prog_ok_d;
            hex_q       <= hex_d;
        end
    end

    assign bus.unlocked    = unlocked_q;
    assign bus.lockout     = lockout_q;
    assign bus.err         = err_q;
    assign bus.prog_ok     = prog_ok_q;
    assign bus.fail_cnt    = fail_cnt_q;
    assign bus.hex_display = hex_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed bench for lock_supervisor with short timing windows (open 8, lockout 16).
module tb_lock_supervisor;

    logic clk;
    logic reset_in;
    int   n_tests;
    int   n_fail;

    lock_supervisor_if bus();

    lock_supervisor #(
        .MAX_FAIL       (3),
        .UNLOCK_CYCLES  (8),
        .LOCKOUT_CYCLES (16),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the given pulses for exactly one sampling edge.
    task automatic pulse(input logic b0, input logic b1, input logic en, input logic pg);
        bus.b0_pulse    = b0;
        bus.b1_pulse    = b1;
        bus.enter_pulse = en;
        bus.prog_pulse  = pg;
        tick();
        bus.b0_pulse    = 1'b0;
        bus.b1_pulse    = 1'b0;
        bus.enter_pulse = 1'b0;
        bus.prog_pulse  = 1'b0;
    endtask

    task automatic digit(input logic b);
        pulse(~b, b, 1'b0, 1'b0);
    endtask

    task automatic send_digits(input logic [7:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) digit(code[i]);
    endtask

    // Digits MSB first, then enter; returns one edge after enter (DUT in CHECK).
    task automatic enter_code(input logic [7:0] code, input int n);
        send_digits(code, n);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        bus.b0_pulse    = 1'b0;
        bus.b1_pulse    = 1'b0;
        bus.enter_pulse = 1'b0;
        bus.prog_pulse  = 1'b0;
        reset_in = 1'b0;
        #23;
        check("rst_unlocked", int'(bus.unlocked), 0);
        check("rst_lockout", int'(bus.lockout), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_prog_ok", int'(bus.prog_ok), 0);
        check("rst_fail_cnt", int'(bus.fail_cnt), 0);
        check("rst_hex", int'(bus.hex_display), 0);
        reset_in = 1'b1;
        tick();

        // 1: correct default code opens for exactly 8 cycles
        enter_code(8'b01011, 5);
        check("t1_check_hex", int'(bus.hex_display), 2);
        check("t1_check_unl", int'(bus.unlocked), 0);
        tick();
        check("t1_open_hex", int'(bus.hex_display), 3);
        check("t1_open_unl", int'(bus.unlocked), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t1_open_hold", int'(bus.unlocked), 1);
        end
        tick();
        check("t1_relock_unl", int'(bus.unlocked), 0);
        check("t1_relock_hex", int'(bus.hex_display), 0);
        check("t1_fail_cnt", int'(bus.fail_cnt), 0);

        // 2: three wrong attempts lead to a 16-cycle lockout
        enter_code(8'b01010, 5);
        tick();
        check("t2_err1", int'(bus.err), 1);
        check("t2_fail1", int'(bus.fail_cnt), 1);
        tick();
        check("t2_err1_pulse", int'(bus.err), 0);
        enter_code(8'b01010, 5);
        tick();
        check("t2_err2", int'(bus.err), 1);
        check("t2_fail2", int'(bus.fail_cnt), 2);
        enter_code(8'b01010, 5);
        tick();
        check("t2_err3", int'(bus.err), 1);
        check("t2_lockout", int'(bus.lockout), 1);
        check("t2_lock_hex", int'(bus.hex_display), 5);
        check("t2_lock_fail", int'(bus.fail_cnt), 0);
        enter_code(8'b01011, 5);
        check("t2_ignored_unl", int'(bus.unlocked), 0);
        check("t2_ignored_lock", int'(bus.lockout), 1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t2_lock_hold", int'(bus.lockout), 1);
        end
        tick();
        check("t2_lock_end", int'(bus.lockout), 0);
        check("t2_lock_end_hex", int'(bus.hex_display), 0);
        check("t2_lock_end_fail", int'(bus.fail_cnt), 0);

        // 3: too many digits, then a double-button digit
        enter_code(8'b010111, 6);
        tick();
        check("t3_long_err", int'(bus.err), 1);
        check("t3_long_fail", int'(bus.fail_cnt), 1);
        digit(1'b0);
        digit(1'b1);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        digit(1'b1);
        digit(1'b1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("t3_both_err", int'(bus.err), 1);
        check("t3_both_fail", int'(bus.fail_cnt), 2);
        check("t3_both_unl", int'(bus.unlocked), 0);

        // 4: reprogram to 11001
        enter_code(8'b01011, 5);
        tick();
        check("t4_open", int'(bus.unlocked), 1);
        check("t4_fail_clr", int'(bus.fail_cnt), 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_prog_hex", int'(bus.hex_display), 4);
        check("t4_prog_unl", int'(bus.unlocked), 1);
        enter_code(8'b11001, 5);
        check("t4_prog_ok", int'(bus.prog_ok), 1);
        check("t4_prog_done_hex", int'(bus.hex_display), 0);
        tick();
        check("t4_prog_ok_pulse", int'(bus.prog_ok), 0);
        enter_code(8'b01011, 5);
        tick();
        check("t4_old_err", int'(bus.err), 1);
        check("t4_old_unl", int'(bus.unlocked), 0);
        enter_code(8'b11001, 5);
        tick();
        check("t4_new_unl", int'(bus.unlocked), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_manual_relock", int'(bus.unlocked), 0);
        check("t4_manual_hex", int'(bus.hex_display), 0);

        // 5: rejected programming and PROG timeout keep the code
        enter_code(8'b11001, 5);
        tick();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        enter_code(8'b11, 2);
        check("t5_short_err", int'(bus.err), 1);
        check("t5_short_prog_ok", int'(bus.prog_ok), 0);
        check("t5_short_hex", int'(bus.hex_display), 0);
        enter_code(8'b11001, 5);
        tick();
        check("t5_code_kept", int'(bus.unlocked), 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        check("t5_prog_wait_hex", int'(bus.hex_display), 4);
        tick();
        check("t5_prog_to_hex", int'(bus.hex_display), 0);
        check("t5_prog_to_err", int'(bus.err), 0);
        check("t5_prog_to_ok", int'(bus.prog_ok), 0);
        enter_code(8'b11001, 5);
        tick();
        check("t5_code_kept2", int'(bus.unlocked), 1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);

        // 6: entry inactivity timeout, then reset mid-PROG restores default
        enter_code(8'b00000, 5);
        tick();
        check("t6_pre_fail", int'(bus.fail_cnt), 1);
        digit(1'b1);
        digit(1'b1);
        for (int i = 0; i < 7; i++) tick();
        check("t6_entry_hex", int'(bus.hex_display), 1);
        tick();
        check("t6_to_hex", int'(bus.hex_display), 0);
        check("t6_to_err", int'(bus.err), 0);
        check("t6_to_fail", int'(bus.fail_cnt), 1);
        enter_code(8'b11001, 5);
        tick();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        digit(1'b1);
        digit(1'b0);
        check("t6_in_prog", int'(bus.hex_display), 4);
        #2;
        reset_in = 1'b0;
        #1;
        check("t6_rst_unl", int'(bus.unlocked), 0);
        check("t6_rst_hex", int'(bus.hex_display), 0);
        check("t6_rst_fail", int'(bus.fail_cnt), 0);
        check("t6_rst_err", int'(bus.err), 0);
        tick();
        reset_in = 1'b1;
        tick();
        enter_code(8'b01011, 5);
        tick();
        check("t6_default_back", int'(bus.unlocked), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
